// File: rtl/sfu_pkg.sv
// Shared SFU definitions: sequencer states, special-function opcodes and the
// core datapath width.
package sfu_pkg;

   localparam int SFU_DW = 24;

   typedef logic [2:0] sfu_op_t;

   localparam sfu_op_t SFU_RCP  = 3'd0;
   localparam sfu_op_t SFU_RSQ  = 3'd1;
   localparam sfu_op_t SFU_SQRT = 3'd2;
   localparam sfu_op_t SFU_SIN  = 3'd3;
   localparam sfu_op_t SFU_COS  = 3'd4;
   localparam sfu_op_t SFU_EXP2 = 3'd5;
   localparam sfu_op_t SFU_LOG2 = 3'd6;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} sfu_state_t;

endpackage

// File: rtl/sfu_lane_sequencer_if.sv
// Request, SFU-core and write-back signals of the lane sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface sfu_lane_sequencer_if #(
   parameter int LANES  = 4,
   parameter int DW     = 24,
   parameter int DEST_W = 5
);
   logic                   req_valid_i;
   logic                   req_ready_o;
   sfu_pkg::sfu_op_t       req_op_i;
   logic [LANES*DW-1:0]    req_operand_i;
   logic [DEST_W-1:0]      req_dest_i;
   logic                   req_bank_i;
   logic [LANES-1:0]       req_lane_mask_i;

   logic [DW-1:0]          sfu_core_operand_o;
   sfu_pkg::sfu_op_t       sfu_core_special_op_o;
   logic                   sfu_valid_o;
   logic [DW-1:0]          sfu_core_result_i;
   logic                   sfu_core_valid_i;

   logic                   wb_valid_o;
   logic                   wb_ready_i;
   logic [LANES*DW-1:0]    wb_result_o;
   logic [DEST_W-1:0]      wb_dest_o;
   logic                   wb_bank_o;
   logic [LANES-1:0]       wb_lane_mask_o;
   logic                   busy_o;

   modport slave (
      input  req_valid_i, req_op_i, req_operand_i, req_dest_i, req_bank_i, req_lane_mask_i,
      input  sfu_core_result_i, sfu_core_valid_i, wb_ready_i,
      output req_ready_o, sfu_core_operand_o, sfu_core_special_op_o, sfu_valid_o,
      output wb_valid_o, wb_result_o, wb_dest_o, wb_bank_o, wb_lane_mask_o, busy_o
   );

   modport master (
      output req_valid_i, req_op_i, req_operand_i, req_dest_i, req_bank_i, req_lane_mask_i,
      output sfu_core_result_i, sfu_core_valid_i, wb_ready_i,
      input  req_ready_o, sfu_core_operand_o, sfu_core_special_op_o, sfu_valid_o,
      input  wb_valid_o, wb_result_o, wb_dest_o, wb_bank_o, wb_lane_mask_o, busy_o
   );
endinterface

// File: rtl/lane_pick.sv
// Finds the next enabled lane: the lowest set mask bit when i_first, otherwise
// the lowest set bit strictly above i_ptr (no wrap-around).
module lane_pick #(
   parameter int LANES = 4,
   parameter int PW    = 2
) (
   input  logic [LANES-1:0] i_mask,
   input  logic [PW-1:0]    i_ptr,
   input  logic             i_first,
   output logic [PW-1:0]    o_lane,
   output logic             o_found
);
   logic [LANES-1:0] w_cand;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_cand
         assign w_cand[gi] = i_mask[gi] && (i_first || (PW'(gi) > i_ptr));
      end
   endgenerate

   assign o_found = |w_cand;

   always_comb begin
      o_lane = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (w_cand[i]) o_lane = PW'(i);
      end
   end
endmodule

// File: rtl/sfu_lane_sequencer.sv
// Serialises one SFU instruction across the enabled register-file lanes onto
// the single shared SFU core and returns one packed write-back.
module sfu_lane_sequencer
   import sfu_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int DW     = SFU_DW,
   parameter int DEST_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   sfu_lane_sequencer_if.slave bus
);
   localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

   sfu_state_t          r_state;
   sfu_state_t          w_state_next;
   sfu_op_t             r_op;
   logic [LANES*DW-1:0] r_operand;
   logic [LANES*DW-1:0] r_result;
   logic [DEST_W-1:0]   r_dest;
   logic                r_bank;
   logic [LANES-1:0]    r_mask;
   logic [PW-1:0]       r_ptr;

   logic                w_first;
   logic [LANES-1:0]    w_pick_mask;
   logic [PW-1:0]       w_next_lane;
   logic                w_found;
   logic                w_accept;
   logic                w_result_ok;

   // In IDLE the picker looks at the incoming mask to seed the pointer.
   assign w_first     = (r_state == IDLE);
   assign w_pick_mask = w_first ? bus.req_lane_mask_i : r_mask;
   assign w_accept    = (r_state == IDLE) && bus.req_valid_i;
   assign w_result_ok = (r_state == WAIT) && bus.sfu_core_valid_i;

   lane_pick #(.LANES(LANES), .PW(PW)) u_lane_pick (
      .i_mask  (w_pick_mask),
      .i_ptr   (r_ptr),
      .i_first (w_first),
      .o_lane  (w_next_lane),
      .o_found (w_found)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = w_found ? ISSUE : WB;
         ISSUE:   w_state_next = WAIT;
         WAIT:    if (bus.sfu_core_valid_i) w_state_next = w_found ? ISSUE : WB;
         WB:      if (bus.wb_ready_i) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_op      <= '0;
         r_operand <= '0;
         r_result  <= '0;
         r_dest    <= '0;
         r_bank    <= 1'b0;
         r_mask    <= '0;
         r_ptr     <= '0;
      end else if (w_accept) begin
         r_op      <= bus.req_op_i;
         r_operand <= bus.req_operand_i;
         r_result  <= '0;
         r_dest    <= bus.req_dest_i;
         r_bank    <= bus.req_bank_i;
         r_mask    <= bus.req_lane_mask_i;
         r_ptr     <= w_next_lane;
      end else if (w_result_ok) begin
         r_result[int'(r_ptr)*DW +: DW] <= bus.sfu_core_result_i;
         if (w_found) r_ptr <= w_next_lane;
      end
   end

   assign bus.req_ready_o           = (r_state == IDLE);
   assign bus.busy_o                = (r_state != IDLE);
   assign bus.sfu_valid_o           = (r_state == ISSUE);
   assign bus.wb_valid_o            = (r_state == WB);
   assign bus.sfu_core_operand_o    = r_operand[int'(r_ptr)*DW +: DW];
   assign bus.sfu_core_special_op_o = r_op;
   assign bus.wb_result_o           = r_result;
   assign bus.wb_dest_o             = r_dest;
   assign bus.wb_bank_o             = r_bank;
   assign bus.wb_lane_mask_o        = r_mask;
endmodule

// File: tb/tb_sfu_lane_sequencer.sv
// Scoreboard bench for sfu_lane_sequencer: a behavioural SFU core with
// programmable latency, expected issues/write-backs queued at request time.
module tb_sfu_lane_sequencer;
   import sfu_pkg::*;

   localparam int LANES  = 4;
   localparam int DW     = 24;
   localparam int DEST_W = 5;

   typedef struct {
      int            cyc;
      logic [DW-1:0] opd;
      sfu_op_t       op;
   } iss_t;

   typedef struct {
      int                  cyc;
      logic [LANES*DW-1:0] res;
      logic [DEST_W-1:0]   dest;
      logic                bank;
      logic [LANES-1:0]    mask;
   } wb_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   sfu_lane_sequencer_if #(.LANES(LANES), .DW(DW), .DEST_W(DEST_W)) bus ();

   sfu_lane_sequencer #(.LANES(LANES), .DW(DW), .DEST_W(DEST_W)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   iss_t iss_q[$];
   wb_t  wb_q[$];
   int   errors     = 0;
   int   checks     = 0;
   int   cyc        = 0;
   int   core_lat   = 1;
   bit   spur_en    = 1'b0;
   bit   rand_ready = 1'b0;
   int   hold_cnt   = 0;
   int   last_acc   = 0;

   initial forever #5 clk_i = ~clk_i;

   initial forever begin
      @(posedge clk_i);
      cyc = cyc + 1;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "watchdog expired");
   end

   // Behavioural core result: an arbitrary but fixed function of op and operand.
   function automatic logic [DW-1:0] core_fn(sfu_op_t op, logic [DW-1:0] x);
      return (x * 24'd5) ^ {op, 21'h0A5A5};
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_req_ready", 128'(bus.req_ready_o), 128'(1));
      chk("rst_sfu_valid", 128'(bus.sfu_valid_o), 128'(0));
      chk("rst_wb_valid", 128'(bus.wb_valid_o), 128'(0));
      chk("rst_busy", 128'(bus.busy_o), 128'(0));
      chk("rst_core_operand", 128'(bus.sfu_core_operand_o), 128'(0));
      chk("rst_core_op", 128'(bus.sfu_core_special_op_o), 128'(0));
      chk("rst_wb_result", 128'(bus.wb_result_o), 128'(0));
      chk("rst_wb_dest", 128'(bus.wb_dest_o), 128'(0));
      chk("rst_wb_bank", 128'(bus.wb_bank_o), 128'(0));
      chk("rst_wb_mask", 128'(bus.wb_lane_mask_o), 128'(0));
   endtask

   // Behavioural SFU core: answers each issue after core_lat cycles, and can
   // inject garbage strobes whenever the sequencer is not waiting for a result.
   initial begin : core_model
      int            cnt;
      sfu_op_t       p_op;
      logic [DW-1:0] p_opd;
      cnt = 0;
      p_op = '0;
      p_opd = '0;
      bus.sfu_core_valid_i  = 1'b0;
      bus.sfu_core_result_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         bus.sfu_core_valid_i = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.sfu_core_valid_i  = 1'b1;
               bus.sfu_core_result_i = core_fn(p_op, p_opd);
            end
         end
         if (bus.sfu_valid_o) begin
            cnt   = core_lat;
            p_op  = bus.sfu_core_special_op_o;
            p_opd = bus.sfu_core_operand_o;
         end
         if (!bus.sfu_core_valid_i && spur_en &&
             (!bus.busy_o || bus.sfu_valid_o || bus.wb_valid_o) &&
             ($urandom_range(0, 1) == 1)) begin
            bus.sfu_core_valid_i  = 1'b1;
            bus.sfu_core_result_i = DW'($urandom);
         end
      end
   end

   initial begin : wb_ready_driver
      bus.wb_ready_i = 1'b1;
      forever begin
         @(posedge clk_i);
         #1;
         if (bus.wb_valid_o && hold_cnt > 0) begin
            bus.wb_ready_i = 1'b0;
            hold_cnt--;
         end else begin
            bus.wb_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   initial begin : monitor
      bit            prev_wbv;
      bit            prev_hs;
      bit            have_cur;
      wb_t           cur;
      iss_t          e;
      logic [DW-1:0] last_opd;
      sfu_op_t       last_op;
      prev_wbv = 1'b0;
      prev_hs  = 1'b0;
      have_cur = 1'b0;
      last_opd = '0;
      last_op  = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            prev_wbv = 1'b0;
            prev_hs  = 1'b0;
         end else begin
            if (prev_hs) chk("ready_after_wb", 128'(bus.req_ready_o), 128'(1));
            if (bus.sfu_valid_o) begin
               if (iss_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_issue: got issue at cycle %0d expected none", cyc);
               end else begin
                  e = iss_q.pop_front();
                  chk("issue_cycle", 128'(cyc), 128'(e.cyc));
                  chk("issue_operand", 128'(bus.sfu_core_operand_o), 128'(e.opd));
                  chk("issue_op", 128'(bus.sfu_core_special_op_o), 128'(e.op));
                  last_opd = e.opd;
                  last_op  = e.op;
               end
            end else if (bus.busy_o && !bus.wb_valid_o) begin
               chk("wait_operand_hold", 128'(bus.sfu_core_operand_o), 128'(last_opd));
               chk("wait_op_hold", 128'(bus.sfu_core_special_op_o), 128'(last_op));
            end
            if (bus.wb_valid_o) begin
               if (!prev_wbv) begin
                  if (wb_q.size() == 0) begin
                     have_cur = 1'b0;
                     checks++;
                     errors++;
                     $display("FAIL unexpected_wb: got wb_valid at cycle %0d expected none", cyc);
                  end else begin
                     have_cur = 1'b1;
                     cur = wb_q.pop_front();
                     chk("wb_cycle", 128'(cyc), 128'(cur.cyc));
                  end
               end
               if (have_cur) begin
                  chk("wb_result", 128'(bus.wb_result_o), 128'(cur.res));
                  chk("wb_dest", 128'(bus.wb_dest_o), 128'(cur.dest));
                  chk("wb_bank", 128'(bus.wb_bank_o), 128'(cur.bank));
                  chk("wb_mask", 128'(bus.wb_lane_mask_o), 128'(cur.mask));
               end
               chk("ready_low_in_wb", 128'(bus.req_ready_o), 128'(0));
            end
            prev_hs  = bus.wb_valid_o && bus.wb_ready_i;
            prev_wbv = bus.wb_valid_o;
         end
      end
   end

   // Called just after a rising edge; returns one cycle after acceptance.
   task automatic send(int lat, sfu_op_t op, logic [LANES*DW-1:0] opd,
                       logic [DEST_W-1:0] dest, logic bank, logic [LANES-1:0] mask);
      int                  t;
      int                  k;
      logic [LANES*DW-1:0] res;
      iss_t                e;
      wb_t                 w;
      bus.req_valid_i     = 1'b1;
      bus.req_op_i        = op;
      bus.req_operand_i   = opd;
      bus.req_dest_i      = dest;
      bus.req_bank_i      = bank;
      bus.req_lane_mask_i = mask;
      t = 0;
      while (!bus.req_ready_o && t < 1000) begin
         @(posedge clk_i);
         #1;
         t++;
      end
      if (!bus.req_ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready_o=0 expected 1 within 1000 cycles");
         bus.req_valid_i = 1'b0;
         return;
      end
      core_lat = lat;
      last_acc = cyc;
      k   = 0;
      res = '0;
      for (int l = 0; l < LANES; l++) begin
         if (mask[l]) begin
            e.cyc = cyc + 1 + k * (lat + 1);
            e.opd = opd[l*DW +: DW];
            e.op  = op;
            iss_q.push_back(e);
            res[l*DW +: DW] = core_fn(op, opd[l*DW +: DW]);
            k++;
         end
      end
      w.cyc  = cyc + k * (lat + 1) + 1;
      w.res  = res;
      w.dest = dest;
      w.bank = bank;
      w.mask = mask;
      wb_q.push_back(w);
      @(posedge clk_i);
      #1;
      bus.req_valid_i     = 1'b0;
      bus.req_op_i        = 3'($urandom);
      bus.req_operand_i   = {$urandom, $urandom, $urandom};
      bus.req_dest_i      = DEST_W'($urandom);
      bus.req_bank_i      = 1'($urandom);
      bus.req_lane_mask_i = LANES'($urandom);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((bus.busy_o || iss_q.size() != 0 || wb_q.size() != 0) && t < 3000) begin
         @(posedge clk_i);
         #1;
         t++;
      end
      if (t >= 3000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy expected idle within 3000 cycles");
      end
   endtask

   initial begin : main
      logic [LANES*DW-1:0] rnd;
      int                  a1;
      bus.req_valid_i     = 1'b0;
      bus.req_op_i        = '0;
      bus.req_operand_i   = '0;
      bus.req_dest_i      = '0;
      bus.req_bank_i      = 1'b0;
      bus.req_lane_mask_i = '0;
      rst_ni = 1'b0;
      #12;
      check_reset_vals();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Full mask, latency 1: issues at +1,+3,+5,+7, write-back at +9.
      send(1, SFU_RCP, {24'h000004, 24'h000003, 24'h000002, 24'h000001}, 5'd5, 1'b1, 4'hF);
      wait_idle();

      // Sparse mask with spurious core strobes outside WAIT.
      rnd = {$urandom, $urandom, $urandom};
      spur_en = 1'b1;
      send(3, SFU_SIN, rnd, 5'd12, 1'b0, 4'b1010);
      wait_idle();
      spur_en = 1'b0;

      // Empty mask goes straight to write-back with zero results.
      rnd = {$urandom, $urandom, $urandom};
      hold_cnt = 2;
      send(2, SFU_EXP2, rnd, 5'd3, 1'b1, 4'b0000);
      wait_idle();

      // Write-back stalled 5 cycles; the queued second request waits for it.
      rnd = {$urandom, $urandom, $urandom};
      hold_cnt = 5;
      send(1, SFU_RSQ, rnd, 5'd7, 1'b0, 4'hF);
      a1 = last_acc;
      rnd = {$urandom, $urandom, $urandom};
      send(1, SFU_COS, rnd, 5'd9, 1'b1, 4'b0110);
      chk("b2b_accept_cycle", 128'(last_acc), 128'(a1 + 15));
      wait_idle();

      // Asynchronous reset while waiting on lane 2; the late result must be dropped.
      rnd = {$urandom, $urandom, $urandom};
      send(6, SFU_LOG2, rnd, 5'd2, 1'b1, 4'hF);
      a1 = last_acc;
      while (cyc < a1 + 17) begin
         @(posedge clk_i);
         #1;
      end
      chk("pre_reset_lane2_operand", 128'(bus.sfu_core_operand_o), 128'(rnd[2*DW +: DW]));
      chk("pre_reset_busy", 128'(bus.busy_o), 128'(1));
      #2;
      rst_ni = 1'b0;
      #1;
      iss_q.delete();
      wb_q.delete();
      check_reset_vals();
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      while (cyc < a1 + 23) begin
         @(posedge clk_i);
         #1;
      end
      chk("late_result_busy", 128'(bus.busy_o), 128'(0));
      chk("late_result_wb_valid", 128'(bus.wb_valid_o), 128'(0));
      chk("late_result_wb_result", 128'(bus.wb_result_o), 128'(0));
      chk("late_result_ready", 128'(bus.req_ready_o), 128'(1));
      rnd = {$urandom, $urandom, $urandom};
      send(2, SFU_SQRT, rnd, 5'd17, 1'b0, 4'hF);
      wait_idle();

      // Randomised traffic with random write-back stalls and spurious strobes.
      rand_ready = 1'b1;
      spur_en    = 1'b1;
      for (int n = 0; n < 40; n++) begin
         rnd = {$urandom, $urandom, $urandom};
         send($urandom_range(1, 4), 3'($urandom_range(0, 6)), rnd,
              DEST_W'($urandom), 1'($urandom), LANES'($urandom));
         if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();
      rand_ready = 1'b0;
      spur_en    = 1'b0;

      chk("issue_queue_drained", 128'(iss_q.size()), 128'(0));
      chk("wb_queue_drained", 128'(wb_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sfu_lane_sequencer.md
# sfu_lane_sequencer

- Serialises one SFU instruction across the four SEU register-file lanes onto the single shared 24-bit SFU core.
- Sits between the control unit's SFU dispatch state and the SFU core.
- Per request: latches the four lane operands, issues each enabled lane to the core one at a time, collects results, then presents one packed write-back to the register files.
- Only one SFU instruction is in flight at a time.

## Interface
Parameters:
- LANES, 4, number of SEU lanes sequenced (counter width = $clog2(LANES))
- DW, 24, SFU operand/result width
- DEST_W, 5, destination register index width

Ports:
- clk_i  in  1  clock; one clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  SFU instruction valid from control unit
- req_ready_o  out  1  sequencer can accept; high only in IDLE
- req_op_i  in  3  special-function opcode
- req_operand_i  in  LANES*DW  lane operands, lane 0 in [DW-1:0]
- req_dest_i  in  DEST_W  destination register
- req_bank_i  in  1  destination bank
- req_lane_mask_i  in  LANES  lanes to execute
- sfu_core_operand_o  out  DW  operand to core
- sfu_core_special_op_o  out  3  opcode to core
- sfu_valid_o  out  1  single-cycle issue strobe to core
- sfu_core_result_i  in  DW  core result
- sfu_core_valid_i  in  1  core result strobe
- wb_valid_o  out  1  packed result valid
- wb_ready_i  in  1  register files accept write-back
- wb_result_o  out  LANES*DW  per-lane results; masked lanes = 0
- wb_dest_o  out  DEST_W  latched destination
- wb_bank_o  out  1  latched bank
- wb_lane_mask_o  out  LANES  latched mask (per-lane write enable)
- busy_o  out  1  state != IDLE

## Operation
- States:
  - IDLE:
    - Accept on req_valid_i && req_ready_o.
    - Latch op, operands, dest, bank and mask; clear the result register.
    - Mask == 0: go to WB. Otherwise go to ISSUE with lane pointer = lowest set mask bit.
  - ISSUE:
    - Drive sfu_valid_o = 1 for exactly one cycle.
    - sfu_core_operand_o = latched operand[pointer]; sfu_core_special_op_o = latched op.
    - Go to WAIT.
  - WAIT:
    - Hold operand/op outputs stable.
    - On sfu_core_valid_i: store sfu_core_result_i into result[pointer].
    - If a higher mask bit remains set: advance pointer to the next set bit and go to ISSUE. Otherwise go to WB.
  - WB:
    - wb_valid_o = 1 with outputs stable until wb_ready_i; then go to IDLE.
- Lane pointer never wraps. Masked lanes are skipped, never issued.
- sfu_core_valid_i outside WAIT is ignored: no state or result change.
- The core has at most one request outstanding; the core never returns a result in the issue cycle.
- Reset mid-operation:
  - Returns to IDLE immediately.
  - The in-flight request is dropped.
  - A late sfu_core_valid_i is ignored.

## Timing
- Reset values: state IDLE, req_ready_o 1, sfu_valid_o 0, wb_valid_o 0, busy_o 0, all data outputs 0, pointer 0.
- Request accepted in cycle 0 → first sfu_valid_o in cycle 1.
- With core latency L (result L cycles after issue) and k enabled lanes:
  - Next issue is the cycle after each result.
  - wb_valid_o rises in cycle k*(L+1)+1.
  - Full mask, L=1: cycle 9.
  - k=0: cycle 1.
- wb_valid_o held while wb_ready_i = 0.
- req_ready_o rises the cycle after the WB handshake, so back-to-back throughput is one request per k*(L+1)+2 cycles.
- All outputs registered or decoded from registered state only; no input-to-output combinational path.

## Structure
- Shared package sfu_pkg:
  - state enum {IDLE, ISSUE, WAIT, WB};
  - 3-bit opcode constants SFU_RCP, SFU_RSQ, SFU_SQRT, SFU_SIN, SFU_COS, SFU_EXP2, SFU_LOG2;
  - SFU_DW = 24.
- Sub-module lane_pick (combinational):
  - Inputs: mask, current pointer, first flag.
  - Outputs: next set lane index and found flag.
  - Reused by the future MEM-state lane sequencer.

## Test plan
- Full mask, L=1, operands {0x000004, 0x000003, 0x000002, 0x000001}, op SFU_RCP, dest 5, bank 1:
  - Four sfu_valid_o pulses in cycles 1, 3, 5, 7 with operands 1, 2, 3, 4.
  - wb_valid_o in cycle 9 with core results packed lane-ordered, dest 5, bank 1.
- Mask 4'b1010, L=3:
  - Only lanes 1 and 3 issued.
  - wb_valid_o in cycle 9; wb_result_o lanes 0 and 2 = 0; wb_lane_mask_o = 4'b1010.
- Mask 0:
  - No sfu_valid_o.
  - wb_valid_o in cycle 1; req_ready_o low until the handshake.
- wb_ready_i held low 5 cycles:
  - wb_* outputs stable throughout.
  - req_ready_o stays 0; second request not accepted until the cycle after wb_ready_i.
- Spurious sfu_core_valid_i in IDLE and ISSUE: no result or state change.
- rst_ni asserted asynchronously during WAIT on lane 2:
  - All outputs return to reset values without a clock edge.
  - Result arriving after reset release is ignored; next request completes normally.
